// File: rtl/iob_pcie_pkg.sv
// ============================================================================
// Module : iob_pcie_pkg
// Brief  : Shared types and constants for the PCIe TX channel sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iob_pcie_pkg;

    localparam int BEAT_WORDS = 2;
    localparam int BEAT_SHIFT = $clog2(BEAT_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/iob_pcie_tx_skid.sv
// ============================================================================
// Module : iob_pcie_tx_skid
// Brief  : Two-entry beat buffer between the TX FIFO read port and CHNL_TX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iob_pcie_tx_skid #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic [1:0]        o_occ,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_d0;
    logic [DATA_W-1:0] r_d1;
    logic [1:0]        r_occ;
    logic              w_pop;

    assign w_pop   = i_pop & (r_occ != 2'd0);
    assign o_dout  = r_d0;
    assign o_occ   = r_occ;
    assign o_empty = (r_occ == 2'd0);

    // r_d0 is always the head; r_d1 only holds data when two beats are queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_occ <= 2'd0;
        end else if (i_flush) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_d0 <= i_din;
                    end else if (r_occ == 2'd1) begin
                        r_d1 <= i_din;
                    end
                    if (r_occ != 2'd2) begin
                        r_occ <= r_occ + 2'd1;
                    end
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_d0 <= r_d1;
                        r_d1 <= i_din;
                    end else begin
                        r_d0 <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_pcie_tx_seq.sv
// ============================================================================
// Module : iob_pcie_tx_seq
// Brief  : Drains TX FIFO beats onto a RIFFA-style CHNL_TX request/ack/stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iob_pcie_tx_seq
    import iob_pcie_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int LEN_W    = 32,
    parameter int ACK_TO_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              last_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              fifo_empty_i,
    output logic              fifo_ren_o,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    output logic              chnl_tx_o,
    output logic              chnl_tx_last_o,
    output logic [LEN_W-1:0]  chnl_tx_len_o,
    output logic [LEN_W-2:0]  chnl_tx_off_o,
    output logic [DATA_W-1:0] chnl_tx_data_o,
    output logic              chnl_tx_data_valid_o,
    input  logic              chnl_tx_data_ren_i,
    input  logic              chnl_tx_ack_i
);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beats;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   r_fetched;
    logic               r_last;
    logic               r_err;
    logic               r_inflight;
    logic [ACK_TO_W-1:0] r_ack_cnt;

    logic               w_active;
    logic               w_start;
    logic               w_consume;
    logic               w_ack_timeout;
    logic [ACK_TO_W-1:0] w_ack_cnt_inc;
    logic [LEN_W:0]     w_len_ext;
    logic [LEN_W-1:0]   w_beats_new;
    logic [1:0]         w_skid_occ;
    logic               w_skid_empty;
    logic [DATA_W-1:0]  w_skid_dout;
    logic [2:0]         w_slots_used;
    logic               w_room;
    logic               w_flush;

    assign w_active = (r_state == ST_REQ) || (r_state == ST_DATA);
    assign w_start  = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Extra MSB keeps len_i = all-ones from wrapping before the divide.
    assign w_len_ext   = {1'b0, len_i} + (LEN_W+1)'(BEAT_WORDS - 1);
    assign w_beats_new = LEN_W'(w_len_ext >> BEAT_SHIFT);

    assign w_ack_cnt_inc = r_ack_cnt + ACK_TO_W'(1);
    assign w_ack_timeout = (w_ack_cnt_inc == {ACK_TO_W{1'b1}});

    assign chnl_tx_data_valid_o = (r_state == ST_DATA) && !w_skid_empty;
    assign w_consume            = chnl_tx_data_valid_o && chnl_tx_data_ren_i;

    // A beat popped this cycle frees its slot in time for a read issued now,
    // which is what sustains one beat per cycle with a two-entry buffer.
    assign w_slots_used = {1'b0, w_skid_occ} - {2'b00, w_consume} + {2'b00, r_inflight};
    assign w_room       = (w_slots_used < 3'd2);
    assign fifo_ren_o   = w_active && !fifo_empty_i && (r_fetched < r_beats) && w_room;

    // Drops prefetched beats left behind by an ACK timeout.
    assign w_flush = (r_state == ST_IDLE);

    assign busy_o         = w_active;
    assign chnl_tx_o      = w_active;
    assign done_o         = (r_state == ST_DONE);
    assign err_o          = r_err;
    assign chnl_tx_last_o = r_last;
    assign chnl_tx_len_o  = r_len;
    assign chnl_tx_off_o  = '0;
    assign chnl_tx_data_o = w_skid_dout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (chnl_tx_ack_i) begin
                    w_state_nxt = (r_beats == '0) ? ST_DONE : ST_DATA;
                end else if (w_ack_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_consume && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = w_start ? ST_REQ : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_beats     <= '0;
            r_remaining <= '0;
            r_fetched   <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_inflight  <= 1'b0;
            r_ack_cnt   <= '0;
        end else begin
            r_inflight <= fifo_ren_o;
            if (w_start) begin
                r_len       <= len_i;
                r_last      <= last_i;
                r_beats     <= w_beats_new;
                r_remaining <= w_beats_new;
                r_fetched   <= '0;
                r_ack_cnt   <= '0;
                r_err       <= 1'b0;
            end else begin
                if (fifo_ren_o) begin
                    r_fetched <= r_fetched + LEN_W'(1);
                end
                if (w_consume) begin
                    r_remaining <= r_remaining - LEN_W'(1);
                end
                if ((r_state == ST_REQ) && !chnl_tx_ack_i) begin
                    r_ack_cnt <= w_ack_cnt_inc;
                    if (w_ack_timeout) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    iob_pcie_tx_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (r_inflight),
        .i_din   (fifo_rdata_i),
        .i_pop   (w_consume),
        .o_dout  (w_skid_dout),
        .o_occ   (w_skid_occ),
        .o_empty (w_skid_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_iob_pcie_tx_seq.sv
// ============================================================================
// Module : tb_iob_pcie_tx_seq
// Brief  : Directed self-checking bench for iob_pcie_tx_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iob_pcie_tx_seq;

    localparam int DATA_W   = 64;
    localparam int LEN_W    = 32;
    localparam int ACK_TO_W = 8;
    localparam int ACK_TO   = (1 << ACK_TO_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [LEN_W-1:0]  len_i = '0;
    logic              last_i = 1'b0;
    logic              busy_o, done_o, err_o;
    logic              fifo_empty_i;
    logic              fifo_ren_o;
    logic [DATA_W-1:0] fifo_rdata_i = '0;
    logic              chnl_tx_o, chnl_tx_last_o;
    logic [LEN_W-1:0]  chnl_tx_len_o;
    logic [LEN_W-2:0]  chnl_tx_off_o;
    logic [DATA_W-1:0] chnl_tx_data_o;
    logic              chnl_tx_data_valid_o;
    logic              chnl_tx_data_ren_i = 1'b0;
    logic              chnl_tx_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    // FIFO model
    logic [DATA_W-1:0] mem [0:255];
    int  rd_ptr = 0;
    int  wr_ptr = 0;
    int  n_ren = 0;
    logic ren_seen = 1'b0;

    // responder controls
    logic ack_en = 1'b1;
    int   ack_delay = 3;
    logic ren_toggle = 1'b0;

    // monitor state
    int cyc = 0;
    logic [DATA_W-1:0] rx_mem [0:255];
    int rx_cyc [0:255];
    int rx_cnt = 0;
    int n_done = 0;
    int done_cyc = 0;
    int n_tx = 0;
    int req_cyc = 0;
    logic acked = 1'b0;
    int len_bad = 0;
    logic [LEN_W-1:0] exp_len = '0;

    assign fifo_empty_i = (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    iob_pcie_tx_seq #(
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .ACK_TO_W (ACK_TO_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .len_i                (len_i),
        .last_i               (last_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .err_o                (err_o),
        .fifo_empty_i         (fifo_empty_i),
        .fifo_ren_o           (fifo_ren_o),
        .fifo_rdata_i         (fifo_rdata_i),
        .chnl_tx_o            (chnl_tx_o),
        .chnl_tx_last_o       (chnl_tx_last_o),
        .chnl_tx_len_o        (chnl_tx_len_o),
        .chnl_tx_off_o        (chnl_tx_off_o),
        .chnl_tx_data_o       (chnl_tx_data_o),
        .chnl_tx_data_valid_o (chnl_tx_data_valid_o),
        .chnl_tx_data_ren_i   (chnl_tx_data_ren_i),
        .chnl_tx_ack_i        (chnl_tx_ack_i)
    );

    always @(negedge clk) begin
        cyc++;
        ren_seen = fifo_ren_o;
        if (chnl_tx_data_valid_o && chnl_tx_data_ren_i) begin
            rx_mem[rx_cnt] = chnl_tx_data_o;
            rx_cyc[rx_cnt] = cyc;
            rx_cnt++;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (chnl_tx_o) begin
            n_tx++;
            if (chnl_tx_len_o !== exp_len) len_bad++;
            if (!acked) req_cyc++;
            if (chnl_tx_ack_i) acked = 1'b1;
        end else begin
            req_cyc = 0;
            acked   = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ren_seen) begin
            fifo_rdata_i = mem[rd_ptr];
            rd_ptr++;
            n_ren++;
        end
        chnl_tx_data_ren_i = ren_toggle ? ~chnl_tx_data_ren_i : 1'b1;
        chnl_tx_ack_i = ack_en && chnl_tx_o && !acked && (req_cyc >= ack_delay);
    end

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic start_xfer(input logic [LEN_W-1:0] len, input logic last);
        @(posedge clk); #1;
        len_i   = len;
        last_i  = last;
        exp_len = len;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int d0;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (n_done != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({busy_o, done_o, err_o, fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_data_valid_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b exp 0000000", {busy_o, done_o, err_o, fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_data_valid_o});
        end
        checks++;
        if ({chnl_tx_len_o, chnl_tx_off_o, chnl_tx_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus: len %h off %h data %h exp 0", chnl_tx_len_o, chnl_tx_off_o, chnl_tx_data_o);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_len8;
        logic [DATA_W-1:0] d [0:3];
        int rx0, ren0, tx0, dn0, lb0;
        logic ok;
        d[0] = 64'hA000_0001_A000_0000; d[1] = 64'hA000_0003_A000_0002;
        d[2] = 64'hA000_0005_A000_0004; d[3] = 64'hA000_0007_A000_0006;
        for (int i = 0; i < 4; i++) push(d[i]);
        rx0 = rx_cnt; ren0 = n_ren; tx0 = n_tx; dn0 = n_done; lb0 = len_bad;
        ack_en = 1'b1; ack_delay = 3; ren_toggle = 1'b0;
        start_xfer(32'd8, 1'b1);
        checks++;
        if (chnl_tx_o !== 1'b1 || busy_o !== 1'b1 || chnl_tx_last_o !== 1'b1) begin
            errors++;
            $display("FAIL len8_req: tx %b busy %b last %b exp 1 1 1", chnl_tx_o, busy_o, chnl_tx_last_o);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL len8_done_timeout: no done_o within 100 cycles"); end
        idle(4);
        checks++;
        if (rx_cnt - rx0 !== 4) begin errors++; $display("FAIL len8_beats: got %0d exp 4", rx_cnt - rx0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_mem[rx0+i] !== d[i]) begin
                errors++;
                $display("FAIL len8_data%0d: got %h exp %h", i, rx_mem[rx0+i], d[i]);
            end
        end
        checks++;
        if (rx_cyc[rx0+3] - rx_cyc[rx0] !== 3) begin
            errors++;
            $display("FAIL len8_consecutive: span %0d exp 3", rx_cyc[rx0+3] - rx_cyc[rx0]);
        end
        checks++;
        if (n_ren - ren0 !== 4) begin errors++; $display("FAIL len8_fifo_reads: got %0d exp 4", n_ren - ren0); end
        checks++;
        if (n_tx - tx0 !== 8) begin errors++; $display("FAIL len8_tx_cycles: got %0d exp 8", n_tx - tx0); end
        checks++;
        if (done_cyc !== rx_cyc[rx0+3] + 1) begin
            errors++;
            $display("FAIL len8_done_cycle: got %0d exp %0d", done_cyc, rx_cyc[rx0+3] + 1);
        end
        checks++;
        if (n_done - dn0 !== 1) begin errors++; $display("FAIL len8_done_count: got %0d exp 1", n_done - dn0); end
        checks++;
        if (len_bad - lb0 !== 0) begin errors++; $display("FAIL len8_len_stable: %0d bad cycles exp 0", len_bad - lb0); end
    endtask

    task automatic test_odd_len;
        logic [DATA_W-1:0] d [0:3];
        int rx0, ren0;
        logic ok;
        d[0] = 64'hB000_0001_B000_0000; d[1] = 64'hB000_0003_B000_0002;
        d[2] = 64'hBEEF_BEEF_B000_0004; d[3] = 64'hB000_0007_B000_0006;
        for (int i = 0; i < 4; i++) push(d[i]);
        rx0 = rx_cnt; ren0 = n_ren;
        start_xfer(32'd5, 1'b0);
        checks++;
        if (chnl_tx_last_o !== 1'b0) begin errors++; $display("FAIL odd_last: got %b exp 0", chnl_tx_last_o); end
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL odd_done_timeout: no done_o within 100 cycles"); end
        idle(10);
        checks++;
        if (rx_cnt - rx0 !== 3) begin errors++; $display("FAIL odd_beats: got %0d exp 3", rx_cnt - rx0); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rx_mem[rx0+i] !== d[i]) begin
                errors++;
                $display("FAIL odd_data%0d: got %h exp %h", i, rx_mem[rx0+i], d[i]);
            end
        end
        checks++;
        if (rx_mem[rx0+2][31:0] !== 32'hB000_0004) begin
            errors++;
            $display("FAIL odd_final_word: got %h exp B0000004", rx_mem[rx0+2][31:0]);
        end
        checks++;
        if (n_ren - ren0 !== 3) begin errors++; $display("FAIL odd_fifo_reads: got %0d exp 3", n_ren - ren0); end
        checks++;
        if (wr_ptr - rd_ptr !== 1) begin errors++; $display("FAIL odd_leftover: got %0d words exp 1", wr_ptr - rd_ptr); end
    endtask

    // The odd-length leftover word is still queued, so any fetch would show.
    task automatic test_zero_len;
        int rx0, ren0, tx0, dn0;
        logic ok;
        rx0 = rx_cnt; ren0 = n_ren; tx0 = n_tx; dn0 = n_done;
        start_xfer(32'd0, 1'b0);
        wait_done(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_done_timeout: no done_o within 50 cycles"); end
        idle(4);
        checks++;
        if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL zero_beats: got %0d exp 0", rx_cnt - rx0); end
        checks++;
        if (n_ren - ren0 !== 0) begin errors++; $display("FAIL zero_fifo_reads: got %0d exp 0", n_ren - ren0); end
        checks++;
        if (n_done - dn0 !== 1) begin errors++; $display("FAIL zero_done_count: got %0d exp 1", n_done - dn0); end
        checks++;
        if (n_tx - tx0 !== 4) begin errors++; $display("FAIL zero_tx_cycles: got %0d exp 4", n_tx - tx0); end
    endtask

    task automatic test_ack_timeout;
        int ren0, tx0, dn0, rx0;
        logic ok;
        logic seen;
        ren0 = n_ren; tx0 = n_tx; dn0 = n_done;
        ack_en = 1'b0;
        start_xfer(32'd4, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < ACK_TO + 50; i++) begin
            @(negedge clk); #2;
            if (err_o) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL to_err: err_o never rose within %0d cycles", ACK_TO + 50); end
        checks++;
        if (chnl_tx_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL to_release: tx %b busy %b exp 0 0", chnl_tx_o, busy_o);
        end
        checks++;
        if (n_tx - tx0 !== ACK_TO) begin errors++; $display("FAIL to_req_cycles: got %0d exp %0d", n_tx - tx0, ACK_TO); end
        idle(3);
        checks++;
        if (n_done - dn0 !== 0) begin errors++; $display("FAIL to_no_done: got %0d exp 0", n_done - dn0); end
        checks++;
        if (n_ren - ren0 !== 1) begin errors++; $display("FAIL to_prefetch: got %0d exp 1", n_ren - ren0); end
        ack_en = 1'b1;
        push(64'hC0DE_0001_C0DE_0000);
        rx0 = rx_cnt; ren0 = n_ren;
        start_xfer(32'd2, 1'b0);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b exp 0", err_o); end
        wait_done(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_recover_timeout: no done_o within 50 cycles"); end
        idle(2);
        checks++;
        if (rx_cnt - rx0 !== 1 || rx_mem[rx0] !== 64'hC0DE_0001_C0DE_0000) begin
            errors++;
            $display("FAIL to_recover_data: beats %0d data %h exp 1 c0de0001c0de0000", rx_cnt - rx0, rx_mem[rx0]);
        end
    endtask

    task automatic test_stall;
        logic [DATA_W-1:0] d [0:7];
        int rx0, ren0, dn0;
        logic ok;
        logic seen;
        for (int i = 0; i < 8; i++) d[i] = {32'hD000_0000 + 32'(2*i+1), 32'hD000_0000 + 32'(2*i)};
        for (int i = 0; i < 4; i++) push(d[i]);
        rx0 = rx_cnt; ren0 = n_ren; dn0 = n_done;
        ren_toggle = 1'b1;
        start_xfer(32'd16, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (n_ren - ren0 == 4) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_first_reads: got %0d exp 4", n_ren - ren0); end
        idle(5);
        checks++;
        if (chnl_tx_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: tx %b err %b exp 1 0", chnl_tx_o, err_o);
        end
        for (int i = 4; i < 8; i++) push(d[i]);
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done_timeout: no done_o within 200 cycles"); end
        idle(3);
        ren_toggle = 1'b0;
        checks++;
        if (rx_cnt - rx0 !== 8) begin errors++; $display("FAIL stall_beats: got %0d exp 8", rx_cnt - rx0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_mem[rx0+i] !== d[i]) begin
                errors++;
                $display("FAIL stall_data%0d: got %h exp %h", i, rx_mem[rx0+i], d[i]);
            end
        end
        checks++;
        if (n_ren - ren0 !== 8 || n_done - dn0 !== 1) begin
            errors++;
            $display("FAIL stall_counts: reads %0d done %0d exp 8 1", n_ren - ren0, n_done - dn0);
        end
    endtask

    task automatic test_reset_mid;
        int rx0, ren0, dn0;
        logic ok;
        logic seen;
        push(64'hE000_0001_E000_0000);
        push(64'hE000_0003_E000_0002);
        push(64'hE000_0005_E000_0004);
        rx0 = rx_cnt; ren0 = n_ren;
        start_xfer(32'd8, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (rx_cnt - rx0 == 2) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rmid_two_beats: got %0d exp 2", rx_cnt - rx0); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_data_valid_o} !== 7'b0
            || chnl_tx_data_o !== '0 || chnl_tx_len_o !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: ctrl %b data %h len %h exp 0",
                     {busy_o, done_o, err_o, fifo_ren_o, chnl_tx_o, chnl_tx_last_o, chnl_tx_data_valid_o},
                     chnl_tx_data_o, chnl_tx_len_o);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (n_ren - ren0 !== 3) begin errors++; $display("FAIL rmid_reads: got %0d exp 3", n_ren - ren0); end
        push(64'hF000_0001_F000_0000);
        push(64'hF000_0003_F000_0002);
        rx0 = rx_cnt; dn0 = n_done;
        start_xfer(32'd4, 1'b1);
        wait_done(50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_done_timeout: no done_o within 50 cycles"); end
        idle(2);
        checks++;
        if (rx_cnt - rx0 !== 2 || rx_mem[rx0] !== 64'hF000_0001_F000_0000
            || rx_mem[rx0+1] !== 64'hF000_0003_F000_0002 || n_done - dn0 !== 1) begin
            errors++;
            $display("FAIL rmid_rerun: beats %0d d0 %h d1 %h done %0d exp 2 f0000001f0000000 f0000003f0000002 1",
                     rx_cnt - rx0, rx_mem[rx0], rx_mem[rx0+1], n_done - dn0);
        end
    endtask

    initial begin
        test_reset;
        test_len8;
        test_odd_len;
        test_zero_len;
        test_ack_timeout;
        test_stall;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
